cpu_clk_sequencer: RTL and testbench

//  Controls the iAPX432 two-phase clocks (clka/clkb) from the 250 MHz fabric clock.
//  The period and clkb phase offset are set at runtime through a valid/ready config port.

---
 rtl/cpu_clk_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cpu_clk_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_sequencer.sv
// iAPX432 two-phase clock sequencer: runtime period/offset config, INIT sequencing,
// run/halt and single-period stepping, all timed from the 250 MHz fabric clock.
module cpu_clk_sequencer #(
    parameter int CW          = 8,
    parameter int DIV_DEFAULT = 50,
    parameter int OFS_DEFAULT = 12,
    parameter int INIT_CYCLES = 16
) (
    input  logic          clk_250,
    input  logic          rst_n,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_div,
    input  logic [CW-1:0] cfg_ofs,
    output logic          cfg_ready,
    output logic          cfg_err,
    input  logic          run_req,
    input  logic          step_req,
    output logic          halted,
    output logic          period_start,
    output logic          init_n,
    output logic          clka,
    output logic          clkb
);
    localparam int IW = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [CW-1:0] div_r, ofs_r, sh_div_r, sh_ofs_r;
    logic [IW-1:0] init_cnt_r, init_cnt_s;
    logic          pend_r;
    logic          running_s, pe_s, accept_s, apply_s;
    logic          clka_s, clkb_s;
    logic          clka_r, clkb_r, period_start_r, init_n_r, halted_r, cfg_ready_r, cfg_err_r;

    function automatic logic cfg_legal(input logic [CW-1:0] d, input logic [CW-1:0] o);
        cfg_legal = (d >= CW'(4)) && (o < d);
    endfunction

    // Position inside the clkb phase, (c - o) mod d; one extra bit so c + d cannot overflow.
    function automatic logic [CW:0] phase_b(input logic [CW-1:0] c, input logic [CW-1:0] d,
                                            input logic [CW-1:0] o);
        if (c >= o) begin
            phase_b = {1'b0, c} - {1'b0, o};
        end else begin
            phase_b = {1'b0, c} + {1'b0, d} - {1'b0, o};
        end
    endfunction

    assign running_s = (state_r != ST_HALTED);
    assign pe_s      = running_s && (cnt_r == (div_r - CW'(1)));
    assign accept_s  = cfg_valid && cfg_ready_r;
    assign apply_s   = pend_r && (pe_s || (state_r == ST_HALTED));
    assign clka_s    = running_s && (cnt_r < (div_r >> 1));
    assign clkb_s    = running_s && (phase_b(cnt_r, div_r, ofs_r) < {1'b0, div_r >> 1});

    // Next-state, period counter and INIT period-end counting.
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        if (running_s && !pe_s) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = '0;
        end
        case (state_r)
            ST_INIT: begin
                if (pe_s && (init_cnt_r == IW'(INIT_CYCLES - 1))) begin
                    state_s = run_req ? ST_RUN : ST_HALTED;
                end else if (pe_s) begin
                    init_cnt_s = init_cnt_r + IW'(1);
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (pe_s && !run_req) begin
                    state_s = ST_HALTED;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (run_req) begin
                    state_s = ST_RUN;
                end else if (step_req) begin
                    state_s = ST_STEP;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            ST_STEP: begin
                if (pe_s) begin
                    state_s = run_req ? ST_RUN : ST_HALTED;
                end else begin
                    state_s = ST_STEP;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge clk_250 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            cnt_r      <= '0;
            init_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            init_cnt_r <= init_cnt_s;
        end
    end

    // Config shadow: latch on accept, apply or discard at period end / while halted.
    always_ff @(posedge clk_250 or negedge rst_n) begin
        if (!rst_n) begin
            div_r       <= CW'(DIV_DEFAULT);
            ofs_r       <= CW'(OFS_DEFAULT);
            sh_div_r    <= '0;
            sh_ofs_r    <= '0;
            pend_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= 1'b0;
        end else if (apply_s) begin
            pend_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= !cfg_legal(sh_div_r, sh_ofs_r);
            if (cfg_legal(sh_div_r, sh_ofs_r)) begin
                div_r <= sh_div_r;
                ofs_r <= sh_ofs_r;
            end
        end else if (accept_s) begin
            sh_div_r    <= cfg_div;
            sh_ofs_r    <= cfg_ofs;
            pend_r      <= 1'b1;
            cfg_ready_r <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r   <= 1'b0;
        end
    end

    // Registered pin outputs; init_n/halted follow the next state so they switch with it.
    always_ff @(posedge clk_250 or negedge rst_n) begin
        if (!rst_n) begin
            clka_r         <= 1'b0;
            clkb_r         <= 1'b0;
            period_start_r <= 1'b0;
            init_n_r       <= 1'b0;
            halted_r       <= 1'b0;
        end else begin
            clka_r         <= clka_s;
            clkb_r         <= clkb_s;
            period_start_r <= running_s && (cnt_r == '0);
            init_n_r       <= (state_s != ST_INIT);
            halted_r       <= (state_s == ST_HALTED);
        end
    end

    assign clka         = clka_r;
    assign clkb         = clkb_r;
    assign period_start = period_start_r;
    assign init_n       = init_n_r;
    assign halted       = halted_r;
    assign cfg_ready    = cfg_ready_r;
    assign cfg_err      = cfg_err_r;
endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Bench for cpu_clk_sequencer: cycle model of the sequencer rules compared every cycle,
// plus directed scenarios with literal timing expectations and a randomized phase.
module tb_cpu_clk_sequencer;
    logic       clk_250 = 1'b0;
    logic       rst_n, cfg_valid, run_req, step_req;
    logic [7:0] cfg_div, cfg_ofs;
    logic       cfg_ready, cfg_err, halted, period_start, init_n, clka, clkb;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    localparam int M_INIT = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;
    int m_mode, m_pos, m_div, m_ofs, m_inits, m_sdiv, m_sofs;
    bit m_pend;
    bit e_clka, e_clkb, e_ps, e_init_n, e_halted, e_ready, e_err;

    cpu_clk_sequencer dut (
        .clk_250(clk_250), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ofs(cfg_ofs), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .run_req(run_req),
        .step_req(step_req), .halted(halted), .period_start(period_start),
        .init_n(init_n), .clka(clka), .clkb(clkb)
    );

    always #2 clk_250 = ~clk_250;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_INIT; m_pos = 0; m_div = 50; m_ofs = 12; m_inits = 0;
        m_pend = 1'b0; m_sdiv = 0; m_sofs = 0;
        e_clka = 0; e_clkb = 0; e_ps = 0; e_init_n = 0; e_halted = 0; e_ready = 1; e_err = 0;
    endtask

    // One clk_250 edge of the sequencer rules, expressed on position-in-period.
    task automatic model_step();
        bit is_run, at_end;
        if (!rst_n) begin
            model_reset();
            return;
        end
        is_run = (m_mode != M_HALT);
        at_end = is_run && (m_pos == m_div - 1);
        e_clka = is_run && (m_pos < m_div / 2);
        e_clkb = is_run && (((m_pos - m_ofs + m_div) % m_div) < m_div / 2);
        e_ps   = is_run && (m_pos == 0);
        e_err  = 0;
        if (m_pend && (at_end || m_mode == M_HALT)) begin
            if (m_sdiv >= 4 && m_sofs < m_sdiv) begin
                m_div = m_sdiv;
                m_ofs = m_sofs;
            end else begin
                e_err = 1;
            end
            m_pend = 0;
        end else if (cfg_valid && !m_pend) begin
            m_pend = 1; m_sdiv = cfg_div; m_sofs = cfg_ofs;
        end
        case (m_mode)
            M_INIT: if (at_end) begin
                m_inits++;
                if (m_inits == 16) m_mode = run_req ? M_RUN : M_HALT;
            end
            M_RUN:  if (at_end && !run_req) m_mode = M_HALT;
            M_HALT: m_mode = run_req ? M_RUN : (step_req ? M_STEP : M_HALT);
            M_STEP: if (at_end) m_mode = run_req ? M_RUN : M_HALT;
            default: m_mode = M_INIT;
        endcase
        m_pos    = (is_run && !at_end) ? m_pos + 1 : 0;
        e_init_n = (m_mode != M_INIT);
        e_halted = (m_mode == M_HALT);
        e_ready  = !m_pend;
    endtask

    task automatic compare_all();
        chk("clka", clka, e_clka);
        chk("clkb", clkb, e_clkb);
        chk("period_start", period_start, e_ps);
        chk("init_n", init_n, e_init_n);
        chk("halted", halted, e_halted);
        chk("cfg_ready", cfg_ready, e_ready);
        chk("cfg_err", cfg_err, e_err);
        if (cfg_err === 1'b1) err_cnt++;
    endtask

    task automatic cycle();
        @(posedge clk_250);
        model_step();
        @(negedge clk_250);
        compare_all();
    endtask

    task automatic send_cfg(input int d, input int o);
        int w = 0;
        while (cfg_ready !== 1'b1 && w < 200) begin
            cycle();
            w++;
        end
        chk("cfg_ready_wait", (w < 200), 1);
        cfg_valid = 1'b1; cfg_div = 8'(d); cfg_ofs = 8'(o);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic count_init(input string name);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (init_n !== 1'b1 && n < 2000);
        chk(name, n, 800);
    endtask

    task automatic measure(input int n, output int per, output int hi, output int off);
        int r1 = -1, r2 = -1, b1 = -1, h = 0;
        logic pa, pb;
        pa = clka; pb = clkb;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (clka && !pa) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            if (r1 >= 0 && r2 < 0 && clka) h++;
            if (clkb && !pb && r1 >= 0 && b1 < 0) b1 = i;
            pa = clka; pb = clkb;
        end
        per = r2 - r1; hi = h; off = b1 - r1;
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_clka"}, clka, 0);
        chk({tag, "_clkb"}, clkb, 0);
        chk({tag, "_init_n"}, init_n, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_ps"}, period_start, 0);
        chk({tag, "_ready"}, cfg_ready, 1);
        chk({tag, "_err"}, cfg_err, 0);
    endtask

    initial begin
        int per, hi, off, ps, kh;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0; cfg_ofs = 8'd0;
        run_req = 1'b1; step_req = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle();
        chk_reset_pins("rst");
        rst_n = 1'b1;
        count_init("init_len");

        // Default timing in RUN.
        measure(130, per, hi, off);
        chk("def_period", per, 50); chk("def_high", hi, 25); chk("def_ofs", off, 12);

        // Reconfigure mid-period to the clkb wrap case.
        for (int i = 0; i < 17; i++) cycle();
        send_cfg(20, 15);
        chk("ready_low_after_accept", cfg_ready, 0);
        for (int i = 0; i < 60; i++) cycle();
        measure(60, per, hi, off);
        chk("cfg_period", per, 20); chk("cfg_high", hi, 10); chk("cfg_ofs", off, 15);

        // Illegal requests are discarded with one error pulse each.
        send_cfg(50, 12);
        for (int i = 0; i < 70; i++) cycle();
        err_cnt = 0;
        send_cfg(3, 1);
        for (int i = 0; i < 70; i++) cycle();
        send_cfg(50, 60);
        for (int i = 0; i < 70; i++) cycle();
        chk("err_pulses", err_cnt, 2);
        measure(130, per, hi, off);
        chk("kept_period", per, 50); chk("kept_ofs", off, 12);

        // Halt mid-period, then single-step one period.
        for (int i = 0; i < 10; i++) cycle();
        run_req = 1'b0;
        for (int i = 0; i < 60; i++) cycle();
        chk("halted_after_stop", halted, 1); chk("halt_clka", clka, 0); chk("halt_clkb", clkb, 0);
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        ps = 0; kh = 0;
        for (int i = 0; i < 75; i++) begin
            cycle();
            ps += int'(period_start); kh += int'(clka);
        end
        chk("step_ps", ps, 1); chk("step_high", kh, 25); chk("step_halted", halted, 1);

        // run_req and step_req together: RUN wins, every period pulses.
        run_req = 1'b1; step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        ps = 0;
        for (int i = 0; i < 139; i++) begin
            cycle();
            ps += int'(period_start);
        end
        chk("both_ps", ps, 3); chk("both_halted", halted, 0);

        // Asynchronous reset mid-period restores defaults and restarts INIT.
        send_cfg(30, 5);
        for (int i = 0; i < 80; i++) cycle();
        for (int i = 0; i < 7; i++) cycle();
        rst_n = 1'b0;
        #1;
        chk_reset_pins("midrst");
        model_reset();
        for (int i = 0; i < 3; i++) cycle();
        rst_n = 1'b1;
        count_init("reinit_len");

        // Randomized traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) run_req = ~run_req;
            step_req  = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 59) == 0);
            cfg_div   = 8'($urandom_range(0, 70));
            cfg_ofs   = 8'($urandom_range(0, 70));
            cycle();
        end
        cfg_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
